// File: rtl/mem_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter_pkg
// Purpose  : Shared types for the two-requester memory bus arbiter: the
//            arbiter FSM state encoding, the requester identifier and a
//            helper that returns the opposite requester.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mem_bus_arbiter_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS_I = 2'd1,
    BUS_D = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  // Requester identifier: instruction fetch or data access.
  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_t;

  // The requester that is not 'id'.
  function automatic req_id_t other_req(input req_id_t id);
    return (id == REQ_I) ? REQ_D : REQ_I;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_bus_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter_rr_pick
// Purpose  : Two-way round-robin selector. A lone pending requester wins;
//            on a tie the requester that was not granted last wins.
// Ports    : req_i  - instruction requester pending
//            req_d  - data requester pending
//            last   - requester granted most recently
//            valid  - at least one requester pending
//            pick   - winning requester (meaningful when valid is high)
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter_rr_pick
  import mem_bus_arbiter_pkg::*;
(
  input  logic    req_i,
  input  logic    req_d,
  input  req_id_t last,
  output logic    valid,
  output req_id_t pick
);

  always_comb begin
    valid = req_i | req_d;
    pick  = REQ_I;
    if (req_i && req_d) begin
      pick = other_req(last);
    end else if (req_d) begin
      pick = REQ_D;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter
// Purpose  : Arbitrates an instruction-fetch requester (I) and a data
//            requester (D) onto one Avalon-MM master port. One transfer at
//            a time: grant, bus phase (stretched by waitrequest), then a
//            one-cycle ack. Ties are resolved round-robin.
// Ports    : clk, reset                - clock, async active-high reset
//            i_addr/i_read/i_write/
//            i_wdata/i_be              - requester I command
//            d_addr/d_read/d_write/
//            d_wdata/d_be              - requester D command
//            i_ack, d_ack              - one-cycle completion pulses
//            rdata                     - data of the last completed read
//            address/read/write/
//            writedata/byteenable      - Avalon master command (registered)
//            waitrequest, readdata     - Avalon slave response
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     i_addr,
  input  logic                  i_read,
  input  logic                  i_write,
  input  logic [DATA_W-1:0]     i_wdata,
  input  logic [DATA_W/8-1:0]   i_be,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [DATA_W-1:0]     d_wdata,
  input  logic [DATA_W/8-1:0]   d_be,
  output logic                  i_ack,
  output logic                  d_ack,
  output logic [DATA_W-1:0]     rdata,
  output logic [ADDR_W-1:0]     address,
  output logic                  read,
  output logic                  write,
  output logic [DATA_W-1:0]     writedata,
  output logic [DATA_W/8-1:0]   byteenable,
  input  logic                  waitrequest,
  input  logic [DATA_W-1:0]     readdata
);

  localparam int BE_W = DATA_W / 8;

  arb_state_t          state_q,      state_d;
  req_id_t             last_q,       last_d;
  logic                is_wr_q,      is_wr_d;
  logic [ADDR_W-1:0]   address_q,    address_d;
  logic [DATA_W-1:0]   writedata_q,  writedata_d;
  logic [BE_W-1:0]     byteenable_q, byteenable_d;
  logic                read_q,       read_d;
  logic                write_q,      write_d;
  logic                i_ack_q,      i_ack_d;
  logic                d_ack_q,      d_ack_d;
  logic [DATA_W-1:0]   rdata_q,      rdata_d;

  logic    pick_valid;
  req_id_t pick;
  logic    win_wr;

  mem_bus_arbiter_rr_pick u_rr_pick (
    .req_i (i_read | i_write),
    .req_d (d_read | d_write),
    .last  (last_q),
    .valid (pick_valid),
    .pick  (pick)
  );

  // A requester raising read and write together is served as a write.
  assign win_wr = (pick == REQ_I) ? i_write : d_write;

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    is_wr_d      = is_wr_q;
    address_d    = address_q;
    writedata_d  = writedata_q;
    byteenable_d = byteenable_q;
    read_d       = read_q;
    write_d      = write_q;
    rdata_d      = rdata_q;
    i_ack_d      = 1'b0;
    d_ack_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          last_d  = pick;
          is_wr_d = win_wr;
          read_d  = ~win_wr;
          write_d = win_wr;
          if (pick == REQ_I) begin
            address_d    = i_addr;
            writedata_d  = i_wdata;
            byteenable_d = i_be;
            state_d      = BUS_I;
          end else begin
            address_d    = d_addr;
            writedata_d  = d_wdata;
            byteenable_d = d_be;
            state_d      = BUS_D;
          end
        end
      end

      BUS_I, BUS_D: begin
        // Command registers are left untouched while waitrequest is high,
        // so the bus stays stable for as long as the slave stalls.
        if (!waitrequest) begin
          if (!is_wr_q) begin
            rdata_d = readdata;
          end
          read_d  = 1'b0;
          write_d = 1'b0;
          i_ack_d = (state_q == BUS_I);
          d_ack_d = (state_q == BUS_D);
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_q       <= REQ_D;
      is_wr_q      <= 1'b0;
      address_q    <= '0;
      writedata_q  <= '0;
      byteenable_q <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      i_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      is_wr_q      <= is_wr_d;
      address_q    <= address_d;
      writedata_q  <= writedata_d;
      byteenable_q <= byteenable_d;
      read_q       <= read_d;
      write_q      <= write_d;
      i_ack_q      <= i_ack_d;
      d_ack_q      <= d_ack_d;
      rdata_q      <= rdata_d;
    end
  end

  assign address    = address_q;
  assign writedata  = writedata_q;
  assign byteenable = byteenable_q;
  assign read       = read_q;
  assign write      = write_q;
  assign i_ack      = i_ack_q;
  assign d_ack      = d_ack_q;
  assign rdata      = rdata_q;

endmodule
`default_nettype wire
